// File: rtl/ase_tx_c1_buffer.sv
// ---------------------------------------------------------------------------
// ase_tx_c1_buffer
//
// Channel-1 transmit request buffer. Write and interrupt requests pushed by
// the AFU are held in a first-word-fall-through FIFO. The head entry is
// offered to the emulator's request consumer over a valid/ready handshake.
// The block also produces the almost-full flow control back to the AFU and
// flags AFU protocol violations.
//
// Ports:
//   clk_32ui          sole clock
//   sys_reset_n       asynchronous active-low reset
//   tx_c1_header      AFU request header
//   tx_c1_data        AFU write data (stored but meaningless for interrupts)
//   tx_c1_wrvalid     push a write request
//   tx_c1_intrvalid   push an interrupt request
//   tx_c1_almostfull  registered almost-full flow control to the AFU
//   out_valid         head entry available
//   out_ready         consumer takes the head entry when out_valid is high
//   out_header        head header
//   out_data          head data
//   out_is_intr       head is an interrupt (1) or a write (0)
//   fill_count        current occupancy
//   overflow_err      sticky: a push was dropped because the FIFO was full
//   proto_err         sticky: wrvalid and intrvalid were high in one cycle
//
// Handshake: the head entry is transferred on a clock edge where out_valid
// and out_ready are both high. out_valid never depends on out_ready, and
// the head fields stay stable until that transfer. The AFU side has no
// ready; it obeys tx_c1_almostfull, and a push into a full FIFO with no
// pop in the same cycle is dropped.
// ---------------------------------------------------------------------------
module ase_tx_c1_buffer #(
   parameter int HDR_WIDTH   = 61,
   parameter int DATA_WIDTH  = 512,
   parameter int DEPTH       = 16,
   parameter int AFULL_SLACK = 4
) (
   input  logic                      clk_32ui,
   input  logic                      sys_reset_n,
   input  logic [HDR_WIDTH-1:0]      tx_c1_header,
   input  logic [DATA_WIDTH-1:0]     tx_c1_data,
   input  logic                      tx_c1_wrvalid,
   input  logic                      tx_c1_intrvalid,
   output logic                      tx_c1_almostfull,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [HDR_WIDTH-1:0]      out_header,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_is_intr,
   output logic [$clog2(DEPTH):0]    fill_count,
   output logic                      overflow_err,
   output logic                      proto_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 1 + HDR_WIDTH + DATA_WIDTH;

   // Entry layout: {is_intr, header, data}
   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_afull;
   logic          r_overflow;
   logic          r_proto;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_push_acc;
   logic [CW-1:0] w_count_next;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_head;

   assign w_push = tx_c1_wrvalid | tx_c1_intrvalid;
   assign w_pop  = out_valid & out_ready;
   assign w_full = (r_count == CW'(DEPTH));
   // When full, a simultaneous pop frees the head slot, which is exactly
   // the slot the write pointer points at, so the push can land there.
   assign w_push_acc = w_push & (~w_full | w_pop);

   // A simultaneous write+interrupt keeps the write; the interrupt is lost.
   assign w_entry = {tx_c1_intrvalid & ~tx_c1_wrvalid, tx_c1_header, tx_c1_data};

   always_comb begin
      w_count_next = r_count;
      case ({w_push_acc, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk_32ui) begin
      if (w_push_acc) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk_32ui or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_afull    <= 1'b0;
         r_overflow <= 1'b0;
         r_proto    <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_next;
         r_afull <= (w_count_next >= CW'(DEPTH - AFULL_SLACK));
         if (w_push & ~w_push_acc) begin
            r_overflow <= 1'b1;
         end
         if (tx_c1_wrvalid & tx_c1_intrvalid) begin
            r_proto <= 1'b1;
         end
      end
   end

   assign w_head           = r_mem[r_rd_ptr];
   assign out_valid        = (r_count != '0);
   assign out_is_intr      = w_head[EW-1];
   assign out_header       = w_head[EW-2:DATA_WIDTH];
   assign out_data         = w_head[DATA_WIDTH-1:0];
   assign fill_count       = r_count;
   assign tx_c1_almostfull = r_afull;
   assign overflow_err     = r_overflow;
   assign proto_err        = r_proto;

endmodule

// File: tb/tb_ase_tx_c1_buffer.sv
module tb_ase_tx_c1_buffer;

   localparam int HDR_W  = 61;
   localparam int DATA_W = 512;
   localparam int DEPTH  = 16;
   localparam int SLACK  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int EW     = 1 + HDR_W + DATA_W;

   // clock / reset
   logic clk_32ui = 1'b0;
   logic sys_reset_n;
   always #5 clk_32ui = ~clk_32ui;

   logic [HDR_W-1:0]  tx_c1_header;
   logic [DATA_W-1:0] tx_c1_data;
   logic              tx_c1_wrvalid;
   logic              tx_c1_intrvalid;
   logic              tx_c1_almostfull;
   logic              out_valid;
   logic              out_ready;
   logic [HDR_W-1:0]  out_header;
   logic [DATA_W-1:0] out_data;
   logic              out_is_intr;
   logic [CNT_W-1:0]  fill_count;
   logic              overflow_err;
   logic              proto_err;

   ase_tx_c1_buffer #(
      .HDR_WIDTH   (HDR_W),
      .DATA_WIDTH  (DATA_W),
      .DEPTH       (DEPTH),
      .AFULL_SLACK (SLACK)
   ) dut (
      .clk_32ui         (clk_32ui),
      .sys_reset_n      (sys_reset_n),
      .tx_c1_header     (tx_c1_header),
      .tx_c1_data       (tx_c1_data),
      .tx_c1_wrvalid    (tx_c1_wrvalid),
      .tx_c1_intrvalid  (tx_c1_intrvalid),
      .tx_c1_almostfull (tx_c1_almostfull),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_header       (out_header),
      .out_data         (out_data),
      .out_is_intr      (out_is_intr),
      .fill_count       (fill_count),
      .overflow_err     (overflow_err),
      .proto_err        (proto_err)
   );

   // scoreboard / reference model
   logic [EW-1:0] exp_q[$];
   logic          m_afull;
   logic          m_ovf;
   logic          m_proto;
   int            n_tests;
   int            n_fail;

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_afull = 1'b0;
      m_ovf   = 1'b0;
      m_proto = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] rep_data(input logic [HDR_W-1:0] h);
      return {8{64'(h)}};
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Called at a negedge: drive one cycle of inputs, compare current outputs
   // with the model, advance the model by the FIFO rules, wait for the next
   // negedge.
   task automatic drive_cycle(input logic wv, input logic iv, input logic [HDR_W-1:0] hdr,
                              input logic [DATA_W-1:0] data, input logic rdy);
      tx_c1_wrvalid   = wv;
      tx_c1_intrvalid = iv;
      tx_c1_header    = hdr;
      tx_c1_data      = data;
      out_ready       = rdy;
      #1;
      chk("out_valid", EW'(out_valid), EW'(exp_q.size() != 0));
      chk("fill_count", EW'(fill_count), EW'(exp_q.size()));
      if (exp_q.size() != 0) chk("head_entry", {out_is_intr, out_header, out_data}, exp_q[0]);
      chk("almostfull", EW'(tx_c1_almostfull), EW'(m_afull));
      chk("overflow_err", EW'(overflow_err), EW'(m_ovf));
      chk("proto_err", EW'(proto_err), EW'(m_proto));
      // pop happens first, so a full FIFO with a pop has room for the push
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (wv | iv) begin
         if (exp_q.size() < DEPTH) exp_q.push_back({iv & ~wv, hdr, data});
         else                      m_ovf = 1'b1;
      end
      if (wv & iv) m_proto = 1'b1;
      m_afull = (exp_q.size() >= DEPTH - SLACK);
      @(negedge clk_32ui);
   endtask

   task automatic push_wr(input logic [HDR_W-1:0] h, input logic rdy);
      drive_cycle(1'b1, 1'b0, h, rep_data(h), rdy);
   endtask

   task automatic idle(input logic rdy);
      drive_cycle(1'b0, 1'b0, '0, '0, rdy);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_clear();
      sys_reset_n     = 1'b0;
      tx_c1_header    = '0;
      tx_c1_data      = '0;
      tx_c1_wrvalid   = 1'b0;
      tx_c1_intrvalid = 1'b0;
      out_ready       = 1'b0;
      repeat (3) @(negedge clk_32ui);
      chk("rst_out_valid", EW'(out_valid), EW'(0));
      chk("rst_fill_count", EW'(fill_count), EW'(0));
      chk("rst_almostfull", EW'(tx_c1_almostfull), EW'(0));
      chk("rst_errors", EW'({overflow_err, proto_err}), EW'(0));
      sys_reset_n = 1'b1;
      @(negedge clk_32ui);

      // three writes streamed straight through
      for (int i = 1; i <= 3; i++) push_wr(HDR_W'(i), 1'b1);
      repeat (4) idle(1'b1);
      chk("drain3_count", EW'(fill_count), EW'(0));

      // almost-full threshold
      for (int i = 0; i < 11; i++) push_wr(HDR_W'(16 + i), 1'b0);
      chk("afull_at_11", EW'(tx_c1_almostfull), EW'(0));
      push_wr(HDR_W'(27), 1'b0);
      chk("afull_at_12", EW'(tx_c1_almostfull), EW'(1));
      idle(1'b1);
      chk("afull_after_pop", EW'(tx_c1_almostfull), EW'(0));
      // fill to 16, then a dropped 17th
      for (int i = 0; i < 5; i++) push_wr(HDR_W'(40 + i), 1'b0);
      chk("full_count", EW'(fill_count), EW'(DEPTH));
      push_wr(HDR_W'(99), 1'b0);
      chk("ovf_count", EW'(fill_count), EW'(DEPTH));
      chk("ovf_flag", EW'(overflow_err), EW'(1));
      // full with push and pop together
      push_wr(HDR_W'(77), 1'b1);
      chk("full_pushpop_count", EW'(fill_count), EW'(DEPTH));
      repeat (DEPTH + 1) idle(1'b1);
      chk("drain_empty", EW'(out_valid), EW'(0));

      // simultaneous write+interrupt, then a real interrupt
      drive_cycle(1'b1, 1'b1, HDR_W'(10), rep_data(HDR_W'(10)), 1'b0);
      chk("proto_flag", EW'(proto_err), EW'(1));
      chk("proto_is_write", EW'(out_is_intr), EW'(0));
      drive_cycle(1'b0, 1'b1, HDR_W'(11), rand_data(), 1'b0);
      idle(1'b1);
      chk("intr_head", EW'({out_is_intr, out_header}), EW'({1'b1, HDR_W'(11)}));
      idle(1'b1);
      idle(1'b1);

      // reset mid-operation, asserted between clock edges
      for (int i = 0; i < 5; i++) push_wr(HDR_W'(50 + i), 1'b0);
      tx_c1_wrvalid = 1'b0;
      #2 sys_reset_n = 1'b0;
      #1;
      chk("async_rst_valid", EW'(out_valid), EW'(0));
      chk("async_rst_count", EW'(fill_count), EW'(0));
      chk("async_rst_afull", EW'(tx_c1_almostfull), EW'(0));
      chk("async_rst_errors", EW'({overflow_err, proto_err}), EW'(0));
      model_clear();
      @(negedge clk_32ui);
      sys_reset_n = 1'b1;
      push_wr(HDR_W'(12), 1'b0);
      chk("post_rst_head", EW'(out_header), EW'(HDR_W'(12)));
      idle(1'b1);
      idle(1'b1);

      // randomized traffic in phases with different push/pop biases
      for (int ph = 0; ph < 6; ph++) begin
         int pw;
         int pr;
         pw = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
         pr = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 50 : 90;
         for (int c = 0; c < 100; c++) begin
            logic wv;
            logic iv;
            logic [HDR_W-1:0] h;
            wv = ($urandom_range(0, 99) < pw);
            iv = ($urandom_range(0, 99) < pw / 3);
            h  = {$urandom, $urandom};
            drive_cycle(wv, iv, h, rand_data(), ($urandom_range(0, 99) < pr));
         end
      end
      repeat (DEPTH + 2) idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
